// File: rtl/sram_req_arbiter_pkg.sv
// rtl/sram_req_arbiter_pkg.sv - shared IDs, size encodings and request bundle for the sram arbiter
package sram_req_arbiter_pkg;

  // Owner IDs stored in the outstanding-transaction FIFO
  localparam logic REQ_ID_INST = 1'b0;
  localparam logic REQ_ID_DATA = 1'b1;

  // SRAM-like transfer size encodings
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Request payload that travels with req through the grant mux
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_req_arbiter_owner_fifo.sv
// rtl/sram_req_arbiter_owner_fifo.sv - 1-bit owner-ID FIFO tracking in-flight transactions
module sram_req_arbiter_owner_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     push_id,
  input  logic                     pop,
  output logic                     head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_pop;
  logic             do_push;

  // Pop is evaluated first, so a push into a full FIFO is legal when the head leaves the same cycle
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
  end

  // Storage, wrapping pointers and occupancy count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_id;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - shares one sram-like port between fetch and load/store requesters
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int OUTS_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          inst_req,
  input  logic                          inst_wr,
  input  logic [1:0]                    inst_size,
  input  logic [3:0]                    inst_wstrb,
  input  logic [31:0]                   inst_addr,
  input  logic [31:0]                   inst_wdata,
  output logic                          inst_addr_ok,
  output logic                          inst_data_ok,
  output logic [31:0]                   inst_rdata,
  input  logic                          data_req,
  input  logic                          data_wr,
  input  logic [1:0]                    data_size,
  input  logic [3:0]                    data_wstrb,
  input  logic [31:0]                   data_addr,
  input  logic [31:0]                   data_wdata,
  output logic                          data_addr_ok,
  output logic                          data_data_ok,
  output logic [31:0]                   data_rdata,
  output logic                          mem_req,
  output logic                          mem_wr,
  output logic [1:0]                    mem_size,
  output logic [3:0]                    mem_wstrb,
  output logic [31:0]                   mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic                          mem_addr_ok,
  input  logic                          mem_data_ok,
  input  logic [31:0]                   mem_rdata,
  output logic [$clog2(OUTS_DEPTH):0]   outs_cnt,
  output logic                          resp_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  sram_req_t inst_r;
  sram_req_t data_r;
  sram_req_t mem_r;

  logic          full;
  logic          empty;
  logic          head;
  logic          grant_inst;
  logic          grant_data;
  logic          accept;
  logic          pop;
  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic          resp_err_q;
  logic          resp_err_d;

  assign inst_r = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb, addr: inst_addr, wdata: inst_wdata};
  assign data_r = '{wr: data_wr, size: data_wstrb == 4'h0 ? data_size : data_size, wstrb: data_wstrb,
                    addr: data_addr, wdata: data_wdata};

  // Grant: nothing when full or in reset; data preferred unless inst has lost too many times in a row
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (!reset && !full) begin
      if (inst_req && data_req) begin
        if (starve_q == SW'(STARVE_LIMIT)) begin
          grant_inst = 1'b1;
        end else begin
          grant_data = 1'b1;
        end
      end else begin
        grant_inst = inst_req;
        grant_data = data_req;
      end
    end
  end

  // Downstream request mux; payload is zero when nobody holds the grant
  always_comb begin
    mem_r = '0;
    if (grant_inst) begin
      mem_r = inst_r;
    end else if (grant_data) begin
      mem_r = data_r;
    end
  end

  assign mem_req   = grant_inst | grant_data;
  assign mem_wr    = mem_r.wr;
  assign mem_size  = mem_r.size;
  assign mem_wstrb = mem_r.wstrb;
  assign mem_addr  = mem_r.addr;
  assign mem_wdata = mem_r.wdata;

  assign accept       = mem_addr_ok & mem_req;
  assign inst_addr_ok = accept & grant_inst;
  assign data_addr_ok = accept & grant_data;

  // Responses come back in issue order; the FIFO head names the owner
  assign pop          = mem_data_ok & ~empty & ~reset;
  assign inst_data_ok = pop & (head == REQ_ID_INST);
  assign data_data_ok = pop & (head == REQ_ID_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  sram_req_arbiter_owner_fifo #(
    .DEPTH (OUTS_DEPTH)
  ) u_owner_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (accept),
    .push_id (grant_data ? REQ_ID_DATA : REQ_ID_INST),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (outs_cnt)
  );

  // Starvation counter: counts data wins that inst actually lost, clears when inst is served or idle
  always_comb begin
    starve_d = starve_q;
    if (!inst_req || (accept && grant_inst)) begin
      starve_d = '0;
    end else if (accept && grant_data && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // A response with nothing outstanding is a protocol error that stays flagged until reset
  always_comb begin
    resp_err_d = resp_err_q | (mem_data_ok & empty);
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q   <= '0;
      resp_err_q <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign resp_err = resp_err_q;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - self-checking bench for sram_req_arbiter
module tb_sram_req_arbiter;
  import sram_req_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 1'b0, inst_wr = 1'b0;
  logic [1:0]  inst_size = '0;
  logic [3:0]  inst_wstrb = '0;
  logic [31:0] inst_addr = '0, inst_wdata = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = '0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [2:0]  outs_cnt;
  logic        resp_err;

  sram_req_arbiter #(.OUTS_DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .outs_cnt(outs_cnt), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of owners in issue order (1 = data), starvation tally, sticky error
  bit mq[$];
  int m_starve = 0;
  bit m_err = 0;
  int e_g = 0;      // 0 none, 1 inst, 2 data
  bit e_acc = 0;
  bit e_pop = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_err = 0;
  endtask

  task automatic drive(input bit ir, input bit dr, input bit mao, input bit mdo, input logic [31:0] rd);
    inst_req = ir; data_req = dr; mem_addr_ok = mao; mem_data_ok = mdo; mem_rdata = rd;
  endtask

  task automatic new_inst_fields();
    inst_wr = 1'b0; inst_size = SIZE_WORD; inst_wstrb = 4'h0;
    inst_addr = $urandom; inst_wdata = $urandom;
  endtask

  task automatic new_data_fields();
    int s;
    s = $urandom_range(0, 2);
    data_size = (s == 0) ? SIZE_BYTE : (s == 1) ? SIZE_HALF : SIZE_WORD;
    data_wr = 1'($urandom_range(0, 1));
    data_wstrb = 4'($urandom);
    data_addr = $urandom; data_wdata = $urandom;
  endtask

  // Mid-cycle: derive expected outputs from the model and compare
  task automatic eval();
    bit full, head;
    logic [31:0] ea, ew, ef;
    @(negedge clk);
    full = (mq.size() == 4);
    e_g = 0;
    if (!reset && !full) begin
      if (inst_req && data_req) e_g = (m_starve == 3) ? 1 : 2;
      else if (data_req) e_g = 2;
      else if (inst_req) e_g = 1;
    end
    e_acc = (e_g != 0) && mem_addr_ok;
    e_pop = !reset && mem_data_ok && (mq.size() > 0);
    head = (mq.size() > 0) ? mq[0] : 1'b0;
    ea = 0; ew = 0; ef = 0;
    if (e_g == 1) begin ea = inst_addr; ew = inst_wdata; ef = 32'({inst_wr, inst_size, inst_wstrb}); end
    if (e_g == 2) begin ea = data_addr; ew = data_wdata; ef = 32'({data_wr, data_size, data_wstrb}); end
    chk1("mem_req", mem_req, e_g != 0);
    chk1("inst_addr_ok", inst_addr_ok, e_acc && e_g == 1);
    chk1("data_addr_ok", data_addr_ok, e_acc && e_g == 2);
    chk1("inst_data_ok", inst_data_ok, e_pop && !head);
    chk1("data_data_ok", data_data_ok, e_pop && head);
    chk32("inst_rdata", inst_rdata, mem_rdata_exp());
    chk32("data_rdata", data_rdata, mem_rdata_exp());
    chk32("outs_cnt", 32'(outs_cnt), 32'(mq.size()));
    chk1("resp_err", resp_err, m_err);
    chk32("mem_addr", mem_addr, ea);
    chk32("mem_wdata", mem_wdata, ew);
    chk32("mem_ctl", 32'({mem_wr, mem_size, mem_wstrb}), ef);
  endtask

  function automatic logic [31:0] mem_rdata_exp();
    return mem_rdata;
  endfunction

  // Clock edge: advance the model with the inputs that were applied this cycle
  task automatic adv();
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (mem_data_ok && mq.size() == 0) m_err = 1;
      if (e_pop) void'(mq.pop_front());
      if (e_acc) mq.push_back(e_g == 2);
      if (!inst_req || (e_acc && e_g == 1)) m_starve = 0;
      else if (e_acc && e_g == 2) m_starve = (m_starve < 3) ? m_starve + 1 : 3;
    end
    #1;
  endtask

  task automatic step();
    eval();
    adv();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bit i_hold, d_hold;
    // Reset state with requests pending: everything quiet
    new_inst_fields(); new_data_fields();
    drive(1, 1, 1, 1, 32'hdead_beef);
    eval();
    chk1("rst_mem_req", mem_req, 1'b0);
    chk32("rst_outs_cnt", 32'(outs_cnt), 32'd0);
    adv();

    // 1. Both request together: data wins, its ID is at the head
    do_reset();
    new_inst_fields(); new_data_fields();
    drive(1, 1, 1, 0, 32'h0);
    eval();
    chk1("t1_data_acc", data_addr_ok, 1'b1);
    chk1("t1_inst_acc", inst_addr_ok, 1'b0);
    adv();
    drive(0, 0, 0, 1, 32'h0bad_cafe);
    eval();
    chk1("t1_head_data", data_data_ok, 1'b1);
    adv();

    // 2. Starvation: three data wins, then inst forced ahead; full blocks grant even with a pop
    do_reset();
    drive(1, 1, 1, 0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      eval();
      chk1("t2_data_acc", data_addr_ok, c < 3);
      chk1("t2_inst_acc", inst_addr_ok, c == 3);
      adv();
    end
    drive(1, 1, 1, 1, 32'h1111_2222);
    eval();
    chk1("t2_full_no_grant", mem_req, 1'b0);
    adv();
    drive(1, 1, 1, 0, 32'h0);
    eval();
    chk1("t2_starve_cleared", data_addr_ok, 1'b1);
    adv();

    // 3. Four inst loads fill the FIFO, then one response drains one
    do_reset();
    drive(1, 0, 1, 0, 32'h0);
    repeat (4) begin new_inst_fields(); step(); end
    eval();
    chk1("t3_full_req", mem_req, 1'b0);
    chk32("t3_full_cnt", 32'(outs_cnt), 32'd4);
    adv();
    drive(0, 0, 0, 1, 32'h1234_5678);
    eval();
    chk1("t3_inst_data_ok", inst_data_ok, 1'b1);
    chk32("t3_inst_rdata", inst_rdata, 32'h1234_5678);
    adv();
    drive(0, 0, 0, 0, 32'h0);
    eval();
    chk32("t3_cnt_after", 32'(outs_cnt), 32'd3);
    adv();

    // 4. inst, data store, inst; responses A, B, C routed in order
    do_reset();
    new_inst_fields(); drive(1, 0, 1, 0, 32'h0); step();
    new_data_fields(); data_wr = 1'b1; drive(0, 1, 1, 0, 32'h0); step();
    new_inst_fields(); drive(1, 0, 1, 0, 32'h0); step();
    drive(0, 0, 0, 1, 32'haaaa_0001);
    eval();
    chk1("t4_A_inst", inst_data_ok, 1'b1);
    chk32("t4_A_rdata", inst_rdata, 32'haaaa_0001);
    adv();
    drive(0, 0, 0, 1, 32'hbbbb_0002);
    eval();
    chk1("t4_B_data", data_data_ok, 1'b1);
    adv();
    drive(0, 0, 0, 1, 32'hcccc_0003);
    eval();
    chk1("t4_C_inst", inst_data_ok, 1'b1);
    chk32("t4_C_rdata", inst_rdata, 32'hcccc_0003);
    adv();

    // 5. Steady push+pop at depth 2 across pointer wrap
    do_reset();
    new_inst_fields(); drive(1, 0, 1, 0, 32'h0); step();
    new_data_fields(); drive(0, 1, 1, 0, 32'h0); step();
    for (int c = 0; c < 10; c++) begin
      int r;
      r = $urandom_range(0, 2);
      new_inst_fields(); new_data_fields();
      drive(r != 1, r != 0, 1, 1, $urandom);
      eval();
      chk32("t5_cnt_steady", 32'(outs_cnt), 32'd2);
      adv();
    end

    // 6. Response while empty is flagged and held; async reset mid-burst clears everything
    do_reset();
    drive(0, 0, 0, 1, 32'h5555_aaaa);
    eval();
    chk1("t6_no_data_ok", inst_data_ok | data_data_ok, 1'b0);
    adv();
    drive(0, 0, 0, 0, 32'h0);
    repeat (3) begin
      eval();
      chk1("t6_err_held", resp_err, 1'b1);
      adv();
    end
    drive(1, 0, 1, 0, 32'h0);
    repeat (3) begin new_inst_fields(); step(); end
    drive(1, 1, 0, 0, 32'h0);
    reset = 1'b1;
    #1;
    chk32("t6_rst_cnt", 32'(outs_cnt), 32'd0);
    chk1("t6_rst_err", resp_err, 1'b0);
    chk1("t6_rst_mem_req", mem_req, 1'b0);
    model_reset();
    eval();
    adv();
    reset = 1'b0;
    drive(0, 0, 0, 0, 32'h0);

    // Randomized traffic against the model
    i_hold = 0; d_hold = 0;
    for (int c = 0; c < 800; c++) begin
      if (!i_hold) begin new_inst_fields(); inst_req = ($urandom_range(0, 99) < 55); end
      else if ($urandom_range(0, 19) == 0) inst_req = 1'b0;
      if (!d_hold) begin new_data_fields(); data_req = ($urandom_range(0, 99) < 55); end
      else if ($urandom_range(0, 19) == 0) data_req = 1'b0;
      mem_addr_ok = ($urandom_range(0, 3) != 0);
      mem_data_ok = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      eval();
      adv();
      i_hold = inst_req && !(e_acc && e_g == 1);
      d_hold = data_req && !(e_acc && e_g == 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
